// File: rtl/verificador_pkg.sv
// Shared encodings for the verificador4 adder monitor.
// VERIFICADOR_HALT_EN adds the absorbing FAIL state.
package verificador_pkg;

  localparam logic [1:0] MODO_HOLD   = 2'b00;
  localparam logic [1:0] MODO_SUMA_C = 2'b01;
  localparam logic [1:0] MODO_SUMA   = 2'b10;
  localparam logic [1:0] MODO_CLR    = 2'b11;

`ifdef VERIFICADOR_HALT_EN
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01,
    FAIL  = 2'b10
  } estado_t;
`else
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    CHECK = 2'b01
  } estado_t;
`endif

endpackage

// File: rtl/modelo_sumador.sv
// Golden model of the sumador result register: {RCO,Q} updated on enabled edges.
module modelo_sumador
  import verificador_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RCI,
  output logic [WIDTH-1:0] Q_EXP,
  output logic             RCO_EXP
);

  logic [WIDTH:0] acc_q;
  logic [WIDTH:0] acc_d;

  // next value of the modelled adder register
  always_comb begin
    acc_d = acc_q;
    if (ENB) begin
      case (MODO)
        MODO_SUMA_C: acc_d = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, RCI};
        MODO_SUMA:   acc_d = {1'b0, A} + {1'b0, B};
        MODO_CLR:    acc_d = {(WIDTH+1){1'b0}};
        default:     acc_d = acc_q;
      endcase
    end else begin
      acc_d = acc_q;
    end
  end

  // model register
  always_ff @(posedge CLK) begin
    if (RESET) begin
      acc_q <= {(WIDTH+1){1'b0}};
    end else begin
      acc_q <= acc_d;
    end
  end

  assign Q_EXP   = acc_q[WIDTH-1:0];
  assign RCO_EXP = acc_q[WIDTH];

endmodule

// File: rtl/verificador4.sv
// Self-checking monitor for the sumador adder: FSM, comparator and saturating counters.
// Define VERIFICADOR_HALT_EN to stop checking (FAIL state) on the first mismatch.
module verificador4
  import verificador_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENB,
  input  logic [1:0]       MODO,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             RCI,
  input  logic [WIDTH-1:0] Q,
  input  logic             RCO,
  output logic             SYNC,
  output logic             ERR,
  output logic             ERR_PULSE,
  output logic [CNT_W-1:0] CUENTA_OK,
  output logic [CNT_W-1:0] CUENTA_ERR
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  estado_t          estado_q, estado_d;
  logic             sync_q, sync_d;
  logic             err_q, err_d;
  logic             err_pulse_q, err_pulse_d;
  logic [CNT_W-1:0] cnt_ok_q, cnt_ok_d;
  logic [CNT_W-1:0] cnt_err_q, cnt_err_d;
  logic [WIDTH-1:0] q_exp_s;
  logic             rco_exp_s;
  logic             defining_s;
  logic             mismatch_s;

  modelo_sumador #(.WIDTH(WIDTH)) u_modelo (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENB     (ENB),
    .MODO    (MODO),
    .A       (A),
    .B       (B),
    .RCI     (RCI),
    .Q_EXP   (q_exp_s),
    .RCO_EXP (rco_exp_s)
  );

  assign defining_s = ENB && (MODO != MODO_HOLD);
  assign mismatch_s = ({RCO, Q} != {rco_exp_s, q_exp_s});

  // next state, verdict and counter updates
  always_comb begin
    estado_d    = estado_q;
    err_d       = err_q;
    err_pulse_d = 1'b0;
    cnt_ok_d    = cnt_ok_q;
    cnt_err_d   = cnt_err_q;
    case (estado_q)
      IDLE: begin
        if (defining_s) begin
          estado_d = CHECK;
        end else begin
          estado_d = IDLE;
        end
      end
      CHECK: begin
        if (mismatch_s) begin
          err_d       = 1'b1;
          err_pulse_d = 1'b1;
          cnt_err_d   = (cnt_err_q == CNT_MAX) ? cnt_err_q : cnt_err_q + CNT_ONE;
`ifdef VERIFICADOR_HALT_EN
          estado_d    = FAIL;
`endif
        end else begin
          cnt_ok_d    = (cnt_ok_q == CNT_MAX) ? cnt_ok_q : cnt_ok_q + CNT_ONE;
        end
      end
`ifdef VERIFICADOR_HALT_EN
      FAIL: estado_d = FAIL;
`endif
      default: estado_d = IDLE;
    endcase
    sync_d = (estado_d == CHECK);
  end

  // state and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      estado_q    <= IDLE;
      sync_q      <= 1'b0;
      err_q       <= 1'b0;
      err_pulse_q <= 1'b0;
      cnt_ok_q    <= {CNT_W{1'b0}};
      cnt_err_q   <= {CNT_W{1'b0}};
    end else begin
      estado_q    <= estado_d;
      sync_q      <= sync_d;
      err_q       <= err_d;
      err_pulse_q <= err_pulse_d;
      cnt_ok_q    <= cnt_ok_d;
      cnt_err_q   <= cnt_err_d;
    end
  end

  assign SYNC       = sync_q;
  assign ERR        = err_q;
  assign ERR_PULSE  = err_pulse_q;
  assign CUENTA_OK  = cnt_ok_q;
  assign CUENTA_ERR = cnt_err_q;

endmodule

// File: tb/tb_verificador4.sv
// Directed bench for verificador4: a behavioural adder drives Q/RCO, with fault injection.
module tb_verificador4;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       ENB;
  logic [1:0] MODO;
  logic [3:0] A, B;
  logic       RCI;
  logic [3:0] Q;
  logic       RCO;

  logic        sync_s, err_s, err_pulse_s;
  logic [15:0] cuenta_ok_s, cuenta_err_s;
  logic        sat_sync_s, sat_err_s, sat_err_pulse_s;
  logic [2:0]  sat_ok_s, sat_cerr_s;

  logic [3:0] add_q   = 4'hA;
  logic       add_rco = 1'b0;
  logic       fault   = 1'b0;
  logic [3:0] fault_val = 4'h3;

  int checks   = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  // behavioural adder under observation (no reset, like the real one)
  always @(posedge CLK) begin
    if (ENB) begin
      case (MODO)
        2'b01:   {add_rco, add_q} <= {1'b0, A} + {1'b0, B} + {4'b0000, RCI};
        2'b10:   {add_rco, add_q} <= {1'b0, A} + {1'b0, B};
        2'b11:   {add_rco, add_q} <= 5'b00000;
        default: {add_rco, add_q} <= {add_rco, add_q};
      endcase
    end
  end

  assign Q   = fault ? fault_val : add_q;
  assign RCO = add_rco;

  verificador4 dut (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .A(A), .B(B), .RCI(RCI),
    .Q(Q), .RCO(RCO), .SYNC(sync_s), .ERR(err_s), .ERR_PULSE(err_pulse_s),
    .CUENTA_OK(cuenta_ok_s), .CUENTA_ERR(cuenta_err_s)
  );

  verificador4 #(.WIDTH(4), .CNT_W(3)) dut_sat (
    .CLK(CLK), .RESET(RESET), .ENB(ENB), .MODO(MODO), .A(A), .B(B), .RCI(RCI),
    .Q(Q), .RCO(RCO), .SYNC(sat_sync_s), .ERR(sat_err_s), .ERR_PULSE(sat_err_pulse_s),
    .CUENTA_OK(sat_ok_s), .CUENTA_ERR(sat_cerr_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge CLK);
      #1;
    end
  endtask

  initial begin
    RESET = 1'b1; ENB = 1'b0; MODO = 2'b00; A = 4'h0; B = 4'h0; RCI = 1'b0;
    step(2);
    check_eq("rst_sync", {31'd0, sync_s}, 32'd0);
    check_eq("rst_err", {31'd0, err_s}, 32'd0);
    check_eq("rst_pulse", {31'd0, err_pulse_s}, 32'd0);
    check_eq("rst_ok", {16'd0, cuenta_ok_s}, 32'd0);
    check_eq("rst_cerr", {16'd0, cuenta_err_s}, 32'd0);
    RESET = 1'b0;

    // hold operations do not define the adder
    ENB = 1'b1; MODO = 2'b00;
    step(5);
    check_eq("idle_sync", {31'd0, sync_s}, 32'd0);
    check_eq("idle_ok", {16'd0, cuenta_ok_s}, 32'd0);
    check_eq("idle_cerr", {16'd0, cuenta_err_s}, 32'd0);
    check_eq("idle_err", {31'd0, err_s}, 32'd0);

    // F+0+1 -> 0 carry 1
    MODO = 2'b01; A = 4'hF; B = 4'h0; RCI = 1'b1;
    step(1);
    check_eq("sync_rise", {31'd0, sync_s}, 32'd1);
    check_eq("ok_first_edge", {16'd0, cuenta_ok_s}, 32'd0);
    step(1);
    check_eq("ok_second_edge", {16'd0, cuenta_ok_s}, 32'd1);
    check_eq("sumac_err", {31'd0, err_s}, 32'd0);

    // 9+8 -> 1 carry 1, then disabled cycles with changing inputs
    MODO = 2'b10; A = 4'h9; B = 4'h8; RCI = 1'b1;
    step(2);
    check_eq("suma_ok", {16'd0, cuenta_ok_s}, 32'd3);
    ENB = 1'b0;
    MODO = 2'b11; A = 4'h1; step(1);
    MODO = 2'b01; A = 4'h7; B = 4'h2; step(1);
    MODO = 2'b10; A = 4'hC; B = 4'hC; step(1);
    check_eq("hold_ok", {16'd0, cuenta_ok_s}, 32'd6);
    check_eq("hold_cerr", {16'd0, cuenta_err_s}, 32'd0);
    check_eq("hold_err", {31'd0, err_s}, 32'd0);

    // single-cycle fault: Q=3 while 1 is expected
    fault = 1'b1; fault_val = 4'h3;
    check_eq("pre_fault_pulse", {31'd0, err_pulse_s}, 32'd0);
    step(1);
    fault = 1'b0;
    check_eq("fault_pulse", {31'd0, err_pulse_s}, 32'd1);
    check_eq("fault_cerr", {16'd0, cuenta_err_s}, 32'd1);
    check_eq("fault_err", {31'd0, err_s}, 32'd1);
    check_eq("fault_ok", {16'd0, cuenta_ok_s}, 32'd6);
    step(1);
    check_eq("pulse_drop", {31'd0, err_pulse_s}, 32'd0);
    check_eq("err_sticky", {31'd0, err_s}, 32'd1);
    check_eq("after_cerr", {16'd0, cuenta_err_s}, 32'd1);
`ifdef VERIFICADOR_HALT_EN
    check_eq("halt_ok_frozen", {16'd0, cuenta_ok_s}, 32'd6);
    check_eq("halt_sync", {31'd0, sync_s}, 32'd0);
    step(2);
    check_eq("halt_ok_still", {16'd0, cuenta_ok_s}, 32'd6);
    check_eq("halt_pulse_once", {31'd0, err_pulse_s}, 32'd0);
`else
    check_eq("resume_ok", {16'd0, cuenta_ok_s}, 32'd7);
    check_eq("resume_sync", {31'd0, sync_s}, 32'd1);
`endif

    // reset beats a simultaneous defining operation
    RESET = 1'b1; ENB = 1'b1; MODO = 2'b01;
    step(1);
    RESET = 1'b0;
    check_eq("mid_rst_sync", {31'd0, sync_s}, 32'd0);
    check_eq("mid_rst_err", {31'd0, err_s}, 32'd0);
    check_eq("mid_rst_ok", {16'd0, cuenta_ok_s}, 32'd0);
    check_eq("mid_rst_cerr", {16'd0, cuenta_err_s}, 32'd0);
    MODO = 2'b11;
    step(1);
    check_eq("clr_sync", {31'd0, sync_s}, 32'd1);
    check_eq("clr_ok0", {16'd0, cuenta_ok_s}, 32'd0);
    MODO = 2'b00;
    step(1);
    check_eq("clr_ok1", {16'd0, cuenta_ok_s}, 32'd1);
    check_eq("clr_err", {31'd0, err_s}, 32'd0);

    // saturation on the 3-bit instance
    step(5);
    check_eq("sat_pre", {29'd0, sat_ok_s}, 32'd6);
    check_eq("wide_pre", {16'd0, cuenta_ok_s}, 32'd6);
    step(3);
    check_eq("sat_ok_max", {29'd0, sat_ok_s}, 32'd7);
    check_eq("wide_ok", {16'd0, cuenta_ok_s}, 32'd9);
`ifndef VERIFICADOR_HALT_EN
    fault = 1'b1; fault_val = 4'h3;
    step(8);
    check_eq("sat_cerr_max", {29'd0, sat_cerr_s}, 32'd7);
    check_eq("wide_cerr", {16'd0, cuenta_err_s}, 32'd8);
    check_eq("repeat_pulse", {31'd0, err_pulse_s}, 32'd1);
    check_eq("sat_ok_hold", {29'd0, sat_ok_s}, 32'd7);
    fault = 1'b0;
    step(1);
    check_eq("repeat_pulse_drop", {31'd0, err_pulse_s}, 32'd0);
    check_eq("wide_ok_resume", {16'd0, cuenta_ok_s}, 32'd10);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
